// File: rtl/bus_reader_pkg.sv
// Shared definitions for the bus_reader slice.
//   state_t    : sequencer states, encoded IDLE=0, GRANT=1, CAPTURE=2, TURN=3
//   DEF_WIDTH  : default bus / data width
//   DEF_N_SRC  : default number of bus sources
//   DEF_DEPTH  : default capture FIFO depth
package bus_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    CAPTURE = 2'd2,
    TURN    = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_SRC = 4;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/bus_reader_sync_fifo.sv
// Small synchronous FIFO holding captured {source id, bus word} entries.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   push         : write push_data at the end of the cycle (ignored when full
//                  unless a pop happens in the same cycle)
//   push_data    : entry to write
//   pop          : drop the head entry (ignored when empty)
//   head         : current head entry
//   count        : number of entries held
module bus_reader_sync_fifo #(
  parameter  int DW    = 34,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is fine then
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bus_reader.sv
// Receiving end of the shared tri-state data bus. Arbitrates round-robin
// among requesting sources, enables one source buffer at a time with a
// turnaround cycle between grants, captures the bus into a FIFO tagged with
// the source id and hands words downstream over valid/ready.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   req          : per-source "has a word to send" (level)
//   oe           : one-hot-or-zero output enables to the source buffers
//   ack          : one-cycle pulse, word from that source captured
//   bus_in       : resolved shared bus
//   data_out     : FIFO head word
//   src_out      : source id of the head word
//   data_valid   : FIFO non-empty
//   data_ready   : downstream accepts the head word
//   fifo_count   : FIFO occupancy
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no grant; pick next winner when a source requests and FIFO has room
// GRANT   | winner enabled onto the bus, settle cycle; abort if its req dropped
// CAPTURE | winner still enabled; bus sampled and pushed, ack pulsed
// TURN    | all enables off for one cycle before the next grant
module bus_reader
  import bus_reader_pkg::*;
#(
  parameter  int N_SRC = DEF_N_SRC,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int SRC_W = $clog2(N_SRC),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] oe,
  output logic [N_SRC-1:0] ack,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] data_out,
  output logic [SRC_W-1:0] src_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CW-1:0]    fifo_count
);

  state_t             state;
  state_t             state_nxt;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   winner_nxt;
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   ptr_nxt;
  logic [SRC_W-1:0]   pick;
  logic [2*N_SRC-1:0] rot_req;
  logic [N_SRC-1:0]   win_hot;
  logic               fifo_full;
  logic               push;

  assign fifo_full = (fifo_count == CW'(DEPTH));
  assign win_hot   = N_SRC'(1) << winner;

  // Rotate req so bit 0 is the source at the pointer; the first set bit is
  // then the winner, offset back by the pointer with wrap.
  always_comb begin
    rot_req = {req, req} >> ptr;
    pick    = ptr;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        pick = (int'(ptr) + i >= N_SRC) ? SRC_W'(int'(ptr) + i - N_SRC)
                                        : SRC_W'(int'(ptr) + i);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    ptr_nxt    = ptr;
    oe         = '0;
    ack        = '0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if ((|req) && !fifo_full) begin
          winner_nxt = pick;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        oe        = win_hot;
        state_nxt = req[winner] ? CAPTURE : TURN;
      end
      CAPTURE: begin
        oe        = win_hot;
        ack       = win_hot;
        push      = 1'b1;
        ptr_nxt   = (winner == SRC_W'(N_SRC - 1)) ? '0 : winner + SRC_W'(1);
        state_nxt = TURN;
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      winner <= '0;
      ptr    <= '0;
    end else begin
      state  <= state_nxt;
      winner <= winner_nxt;
      ptr    <= ptr_nxt;
    end
  end

  assign data_valid = (fifo_count != '0);

  bus_reader_sync_fifo #(
    .DW    (WIDTH + SRC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({winner, bus_in}),
    .pop       (data_valid & data_ready),
    .head      ({src_out, data_out}),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_bus_reader.sv
// Self-checking bench for bus_reader: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// timeline-based model (grant cycle arithmetic, queue for the FIFO).
module tb_bus_reader;

  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 4;

  logic          clock;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  oe;
  logic [N-1:0]  ack;
  logic [W-1:0]  bus_in;
  logic [W-1:0]  data_out;
  logic [1:0]    src_out;
  logic          data_valid;
  logic          data_ready;
  logic [2:0]    fifo_count;

  bus_reader #(.N_SRC(N), .WIDTH(W), .DEPTH(D), .SRC_W(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .oe         (oe),
    .ack        (ack),
    .bus_in     (bus_in),
    .data_out   (data_out),
    .src_out    (src_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Source buffers: each source presents word[i] on the bus while enabled.
  logic [W-1:0] word [N];
  logic         hold_words;
  logic [W-1:0] hold_val;

  always_comb begin
    bus_in = '0;
    for (int i = 0; i < N; i++) begin
      if (oe[i]) bus_in = word[i];
    end
  end

  // Model: a transaction granted at cycle g drives oe in g and g+1, captures
  // at the end of g+1 (ack in g+1), then the bus is free for a new decision
  // at the end of g+3. An abort (req low during g) frees it at the end of g+2.
  typedef struct { logic [1:0] src; logic [W-1:0] data; } ent_t;
  ent_t         q[$];
  int           cyc = 0;
  bit           m_known = 0;
  bit           m_busy = 0;
  bit           m_abort = 0;
  int           m_g, m_free, m_w, m_pre;
  int           m_ptr = 0;
  logic [N-1:0] m_oe = '0;
  logic [N-1:0] m_ack = '0;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_busy  = 0;
      m_ptr   = 0;
      m_known = 1;
    end else if (m_known) begin
      m_pre = q.size();
      if (m_pre > 0 && data_ready) void'(q.pop_front());
      if (m_busy) begin
        if (cyc == m_g && !req[m_w]) begin
          m_abort = 1;
          m_free  = m_g + 2;
        end
        if (cyc == m_g + 1 && !m_abort) begin
          q.push_back('{src: 2'(m_w), data: word[m_w]});
          m_ptr = (m_w + 1) % N;
        end
        if (cyc + 1 == m_free) m_busy = 0;
      end else if (req != 0 && m_pre < D) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_w = (m_ptr + k) % N;
            break;
          end
        end
        m_busy  = 1;
        m_abort = 0;
        m_g     = cyc + 1;
        m_free  = cyc + 4;
      end
    end
    cyc++;
    m_oe  = '0;
    m_ack = '0;
    if (m_busy && (cyc == m_g || (cyc == m_g + 1 && !m_abort))) m_oe[m_w] = 1'b1;
    if (m_busy && cyc == m_g + 1 && !m_abort) m_ack[m_w] = 1'b1;
  end

  // Per-cycle compare, then refresh idle sources' words (never while enabled).
  always @(negedge clock) begin
    if (m_known) begin
      chk("oe", 64'(oe), 64'(m_oe));
      chk("ack", 64'(ack), 64'(m_ack));
      chk("data_valid", 64'(data_valid), 64'(q.size() > 0));
      chk("fifo_count", 64'(fifo_count), 64'(q.size()));
      if (q.size() > 0) begin
        chk("data_out", 64'(data_out), 64'(q[0].data));
        chk("src_out", 64'(src_out), 64'(q[0].src));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (hold_words) word[i] = hold_val;
      else if (!m_oe[i]) word[i] = $urandom;
    end
  end

  task automatic do_reset();
    reset      = 1'b1;
    req        = '0;
    data_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ack(input string name, output int src);
    src = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (ack != 0) begin
        for (int i = 0; i < N; i++) if (ack[i]) src = i;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s actual=no_ack_in_20_cycles expected=ack", name);
  endtask

  int s, n, prev;

  initial begin
    reset      = 1'b1;
    req        = '0;
    data_ready = 1'b0;
    hold_words = 1'b0;
    hold_val   = '0;
    repeat (3) @(negedge clock);
    chk("reset_oe", 64'(oe), 64'h0);
    chk("reset_ack", 64'(ack), 64'h0);
    chk("reset_valid", 64'(data_valid), 64'h0);
    chk("reset_count", 64'(fifo_count), 64'h0);
    chk("reset_data_out", 64'(data_out), 64'h0);
    chk("reset_src_out", 64'(src_out), 64'h0);
    reset = 1'b0;

    // single word from source 2
    hold_val   = 32'hDEADBEEF;
    hold_words = 1'b1;
    repeat (2) @(negedge clock);
    req = 4'b0100;
    @(negedge clock);
    chk("single_oe_c1", 64'(oe), 64'h4);
    @(negedge clock);
    chk("single_oe_c2", 64'(oe), 64'h4);
    chk("single_ack_c2", 64'(ack), 64'h4);
    req = '0;
    @(negedge clock);
    chk("single_valid_c3", 64'(data_valid), 64'h1);
    chk("single_data_c3", 64'(data_out), 64'hDEADBEEF);
    chk("single_src_c3", 64'(src_out), 64'h2);
    chk("single_oe_c3", 64'(oe), 64'h0);
    data_ready = 1'b1;
    repeat (3) @(negedge clock);
    hold_words = 1'b0;

    // round-robin with all sources requesting
    do_reset();
    data_ready = 1'b1;
    req        = 4'b1111;
    prev       = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack("rr_wait", s);
      chk("rr_order", 64'(s), 64'(k % N));
      if (k > 0) chk("rr_spacing", 64'(cyc - prev), 64'd4);
      prev = cyc;
    end
    req = '0;
    repeat (4) @(negedge clock);

    // full stall
    do_reset();
    req = 4'b0001;
    n   = 0;
    repeat (40) begin
      @(negedge clock);
      if (ack != 0) n++;
    end
    chk("full_captures", 64'(n), 64'd4);
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_oe_idle", 64'(oe), 64'h0);
    data_ready = 1'b1;
    @(negedge clock);
    data_ready = 1'b0;
    chk("full_count_after_pop", 64'(fifo_count), 64'd3);
    @(negedge clock);
    chk("full_regrant_oe", 64'(oe), 64'h1);
    req        = '0;
    data_ready = 1'b1;
    repeat (10) @(negedge clock);

    // abort: pointer parked at 1, source 2 drops req during GRANT
    do_reset();
    data_ready = 1'b1;
    req        = 4'b0001;
    wait_ack("abort_setup", s);
    chk("abort_setup_src", 64'(s), 64'd0);
    req = '0;
    repeat (4) @(negedge clock);
    req = 4'b0100;
    @(negedge clock);
    chk("abort_grant_oe", 64'(oe), 64'h4);
    req = '0;
    @(negedge clock);
    chk("abort_turn_oe", 64'(oe), 64'h0);
    n = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack != 0) n++;
    end
    chk("abort_no_ack", 64'(n), 64'd0);
    chk("abort_no_push", 64'(fifo_count), 64'd0);
    req = 4'b0101;
    wait_ack("abort_next", s);
    chk("abort_ptr_kept", 64'(s), 64'd2);
    req = '0;
    repeat (6) @(negedge clock);

    // simultaneous push and pop at count 2
    do_reset();
    req = 4'b0001;
    wait_ack("pp_1", s);
    wait_ack("pp_2", s);
    wait_ack("pp_3", s);
    chk("pp_count_before", 64'(fifo_count), 64'd2);
    data_ready = 1'b1;
    @(negedge clock);
    data_ready = 1'b0;
    chk("pp_count_after", 64'(fifo_count), 64'd2);
    req        = '0;
    data_ready = 1'b1;
    repeat (10) @(negedge clock);

    // reset during CAPTURE of source 3 (pointer would otherwise favour 3)
    do_reset();
    data_ready = 1'b1;
    req        = 4'b1100;
    wait_ack("rst_first", s);
    chk("rst_first_src", 64'(s), 64'd2);
    wait_ack("rst_second", s);
    chk("rst_second_src", 64'(s), 64'd3);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_oe", 64'(oe), 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_count", 64'(fifo_count), 64'h0);
    chk("rst_valid", 64'(data_valid), 64'h0);
    reset = 1'b0;
    wait_ack("rst_after", s);
    chk("rst_after_src", 64'(s), 64'd2);

    // randomized traffic, checked by the model every cycle
    for (int t = 0; t < 2500; t++) begin
      @(negedge clock);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if (t % 400 < 200) data_ready = ($urandom_range(0, 3) != 0);
      else               data_ready = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 499) == 0);
    end
    reset      = 1'b0;
    req        = '0;
    data_ready = 1'b1;
    repeat (10) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
